ahb_spi_slave: RTL and testbench

AHB_SPI_SLAVE -- requirements
Module: ahb_spi_slave

---
 rtl/ahb_spi_slave.sv | 240 ++++++++++++++++++++++++
 tb/tb_ahb_spi_slave.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_spi_slave.sv
// AHB-Lite register front end for an SPI mode-0 slave. The SPI pins are
// asynchronous and are sampled into the HCLK domain. All shifting runs from
// edges detected on the synchronised SCLK.
module ahb_spi_slave #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        HSEL,
  input  logic        HREADY,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [31:0] HWDATA,
  output logic [31:0] HRDATA,
  output logic        HREADYOUT,
  input  logic        SCLK,
  input  logic        MOSI,
  input  logic        CS_N,
  output logic        MISO,
  output logic        MISO_EN,
  output logic        IRQ
);

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  state_t state_q, state_d;

  logic [SYNC_STAGES-1:0] sclk_sync_q, mosi_sync_q, csn_sync_q, vld_sync_q;
  logic sclk_prev_q, csn_prev_q, armed_q;
  logic sclk_s, mosi_s, csn_s;
  logic sclk_rise, sclk_fall, csn_fall, csn_rise;

  logic       wr_q, rd_q;
  logic [1:0] addr_q;
  logic       wr_ctrl, wr_tx, wr_stat, rd_rx;

  logic       en_q, en_d, irqen_q, irqen_d;
  logic [7:0] txdata_q, txdata_d, rxdata_q, rxdata_d;
  logic       rxvalid_q, rxvalid_d, txfull_q, txfull_d;
  logic       overrun_q, overrun_d, txunder_q, txunder_d;
  logic [2:0] bitcnt_q, bitcnt_d;
  logic [7:0] rx_sh_q, rx_sh_d, tx_sh_q, tx_sh_d;
  logic       pend_q, pend_d;
  logic       irq_q, irq_d;
  logic       load, byte_done;
  logic       unused_bits;

  assign unused_bits = ^{HADDR[31:4], HADDR[1:0], HTRANS[0], HWDATA[31:8]};

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  assign csn_s     = csn_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign sclk_fall = ~sclk_s & sclk_prev_q;
  // A CS_N fall only counts once a genuine high has been seen since reset,
  // so CS_N already low when reset is released cannot start a frame.
  assign csn_fall  = ~csn_s & csn_prev_q & armed_q;
  assign csn_rise  = csn_s & ~csn_prev_q;

  // Input synchronisers, edge-detect history and post-reset arming
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      sclk_sync_q <= '0;
      mosi_sync_q <= '0;
      csn_sync_q  <= '1;
      vld_sync_q  <= '0;
      sclk_prev_q <= 1'b0;
      csn_prev_q  <= 1'b1;
      armed_q     <= 1'b0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], SCLK};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], MOSI};
      csn_sync_q  <= {csn_sync_q[SYNC_STAGES-2:0], CS_N};
      vld_sync_q  <= {vld_sync_q[SYNC_STAGES-2:0], 1'b1};
      sclk_prev_q <= sclk_s;
      csn_prev_q  <= csn_s;
      armed_q     <= armed_q | (vld_sync_q[SYNC_STAGES-1] & csn_s);
    end
  end

  // AHB address phase capture
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      wr_q   <= 1'b0;
      rd_q   <= 1'b0;
      addr_q <= 2'd0;
    end else begin
      wr_q <= HSEL & HTRANS[1] & HREADY & HWRITE;
      rd_q <= HSEL & HTRANS[1] & HREADY & ~HWRITE;
      if (HSEL & HTRANS[1] & HREADY) addr_q <= HADDR[3:2];
    end
  end

  assign wr_ctrl = wr_q & (addr_q == 2'd0);
  assign wr_tx   = wr_q & (addr_q == 2'd1);
  assign wr_stat = wr_q & (addr_q == 2'd3);
  assign rd_rx   = rd_q & (addr_q == 2'd2);

  // Read mux driven from the registered address
  always_comb begin
    HRDATA = '0;
    case (addr_q)
      2'd0: HRDATA = {30'd0, irqen_q, en_q};
      2'd1: HRDATA = {24'd0, txdata_q};
      2'd2: HRDATA = {24'd0, rxdata_q};
      default: HRDATA = {27'd0, txunder_q, overrun_q, (state_q == SHIFT), txfull_q, rxvalid_q};
    endcase
  end

  // FSM next state, shifters and register/status updates; set events
  // are applied after bus writes and clears so they take priority
  always_comb begin
    state_d   = state_q;
    en_d      = en_q;
    irqen_d   = irqen_q;
    txdata_d  = txdata_q;
    rxdata_d  = rxdata_q;
    rxvalid_d = rxvalid_q;
    txfull_d  = txfull_q;
    overrun_d = overrun_q;
    txunder_d = txunder_q;
    bitcnt_d  = bitcnt_q;
    rx_sh_d   = rx_sh_q;
    tx_sh_d   = tx_sh_q;
    pend_d    = pend_q;
    load      = 1'b0;
    byte_done = 1'b0;

    if (wr_ctrl) {irqen_d, en_d} = HWDATA[1:0];
    if (wr_tx) begin
      txdata_d = HWDATA[7:0];
      txfull_d = 1'b1;
    end
    if (wr_stat) begin
      if (HWDATA[3]) overrun_d = 1'b0;
      if (HWDATA[4]) txunder_d = 1'b0;
    end
    if (rd_rx) rxvalid_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (csn_fall && en_q) begin
          state_d  = SHIFT;
          load     = 1'b1;
          bitcnt_d = 3'd0;
          rx_sh_d  = 8'd0;
          pend_d   = 1'b0;
        end
      end
      SHIFT: begin
        if (csn_rise || !en_q) begin
          state_d  = IDLE;
          bitcnt_d = 3'd0;
          rx_sh_d  = 8'd0;
          pend_d   = 1'b0;
        end else if (sclk_rise) begin
          rx_sh_d  = {rx_sh_q[6:0], mosi_s};
          bitcnt_d = bitcnt_q + 3'd1;
          // The next byte is committed on its first rise, so a master that
          // ends the frame after one byte never consumes or underruns TX.
          if (pend_q) begin
            load   = 1'b1;
            pend_d = 1'b0;
          end
          if (bitcnt_q == 3'd7) begin
            byte_done = 1'b1;
            pend_d    = 1'b1;
          end
        end else if (sclk_fall && !pend_q) begin
          tx_sh_d = {tx_sh_q[6:0], 1'b0};
        end
      end
      default: state_d = IDLE;
    endcase

    if (load) begin
      if (wr_tx) begin
        tx_sh_d  = HWDATA[7:0];
        txfull_d = 1'b0;
      end else if (txfull_q) begin
        tx_sh_d  = txdata_q;
        txfull_d = 1'b0;
      end else begin
        tx_sh_d   = 8'hFF;
        txunder_d = 1'b1;
      end
    end

    if (byte_done) begin
      rxdata_d  = {rx_sh_q[6:0], mosi_s};
      rxvalid_d = 1'b1;
      if (rxvalid_q && !rd_rx) overrun_d = 1'b1;
    end

    irq_d = irqen_d & (rxvalid_d | overrun_d);
  end

  // State and register storage
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      state_q   <= IDLE;
      en_q      <= 1'b0;
      irqen_q   <= 1'b0;
      txdata_q  <= 8'd0;
      rxdata_q  <= 8'd0;
      rxvalid_q <= 1'b0;
      txfull_q  <= 1'b0;
      overrun_q <= 1'b0;
      txunder_q <= 1'b0;
      bitcnt_q  <= 3'd0;
      rx_sh_q   <= 8'd0;
      tx_sh_q   <= 8'd0;
      pend_q    <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      en_q      <= en_d;
      irqen_q   <= irqen_d;
      txdata_q  <= txdata_d;
      rxdata_q  <= rxdata_d;
      rxvalid_q <= rxvalid_d;
      txfull_q  <= txfull_d;
      overrun_q <= overrun_d;
      txunder_q <= txunder_d;
      bitcnt_q  <= bitcnt_d;
      rx_sh_q   <= rx_sh_d;
      tx_sh_q   <= tx_sh_d;
      pend_q    <= pend_d;
      irq_q     <= irq_d;
    end
  end

  // Between bytes, MISO previews the MSB of the byte that will be committed
  assign MISO_EN   = (state_q == SHIFT);
  assign MISO      = MISO_EN & (pend_q ? (txfull_q ? txdata_q[7] : 1'b1) : tx_sh_q[7]);
  assign IRQ       = irq_q;
  assign HREADYOUT = 1'b1;

endmodule

// File: tb/tb_ahb_spi_slave.sv
// Directed bench for ahb_spi_slave: a register-access vector table followed by
// hand-written SPI frame sequences driven at SCLK = HCLK/10.
module tb_ahb_spi_slave;

  logic        HCLK = 1'b0;
  logic        HRESETn = 1'b0;
  logic        HSEL = 1'b0;
  logic        HREADY = 1'b1;
  logic [31:0] HADDR = '0;
  logic [1:0]  HTRANS = 2'b00;
  logic        HWRITE = 1'b0;
  logic [31:0] HWDATA = '0;
  logic [31:0] HRDATA;
  logic        HREADYOUT;
  logic        SCLK = 1'b0;
  logic        MOSI = 1'b0;
  logic        CS_N = 1'b1;
  logic        MISO;
  logic        MISO_EN;
  logic        IRQ;

  int n_checks = 0;
  int n_errors = 0;

  ahb_spi_slave #(.SYNC_STAGES(2)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HREADY(HREADY),
    .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HWDATA(HWDATA),
    .HRDATA(HRDATA), .HREADYOUT(HREADYOUT), .SCLK(SCLK), .MOSI(MOSI),
    .CS_N(CS_N), .MISO(MISO), .MISO_EN(MISO_EN), .IRQ(IRQ)
  );

  always #5 HCLK = ~HCLK;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp;
    string       name;
  } vec_t;

  vec_t vecs[16];

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge HCLK);
      #1;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic ahb_write(input logic [31:0] addr, input logic [31:0] data);
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = addr;
    tick(1);
    HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HWDATA = data;
    tick(1);
  endtask

  task automatic ahb_read(input logic [31:0] addr, output logic [31:0] data);
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = addr;
    tick(1);
    HSEL = 1'b0; HTRANS = 2'b00;
    data = HRDATA;
    tick(1);
  endtask

  task automatic read_check(input string name, input logic [31:0] addr, input logic [31:0] exp);
    logic [31:0] d;
    ahb_read(addr, d);
    check(name, d, exp);
  endtask

  // Mode-0 master: MOSI set while SCLK low, MISO sampled just before the rise
  task automatic spi_xfer(input logic [7:0] tx, input int nbits,
                          output logic [7:0] rx, output logic en_seen);
    rx = 8'h00;
    en_seen = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      MOSI = tx[7-i];
      tick(5);
      rx[7-i] = MISO;
      en_seen = en_seen | MISO_EN;
      SCLK = 1'b1;
      tick(5);
      SCLK = 1'b0;
    end
    tick(5);
  endtask

  logic [7:0] rxb;
  logic       ens;

  initial begin
    vecs[0]  = '{1'b0, 32'h0, 32'h0,        32'h0,  "rst_ctrl"};
    vecs[1]  = '{1'b0, 32'h4, 32'h0,        32'h0,  "rst_txdata"};
    vecs[2]  = '{1'b0, 32'h8, 32'h0,        32'h0,  "rst_rxdata"};
    vecs[3]  = '{1'b0, 32'hC, 32'h0,        32'h0,  "rst_status"};
    vecs[4]  = '{1'b1, 32'h0, 32'hFFFFFFFF, 32'h0,  "wr_ctrl_all"};
    vecs[5]  = '{1'b0, 32'h0, 32'h0,        32'h3,  "ctrl_unused_zero"};
    vecs[6]  = '{1'b1, 32'h4, 32'h00000123, 32'h0,  "wr_tx_123"};
    vecs[7]  = '{1'b0, 32'h4, 32'h0,        32'h23, "tx_low_byte"};
    vecs[8]  = '{1'b0, 32'hC, 32'h0,        32'h2,  "txfull_set"};
    vecs[9]  = '{1'b1, 32'h4, 32'h000000A5, 32'h0,  "wr_tx_over"};
    vecs[10] = '{1'b0, 32'h4, 32'h0,        32'hA5, "tx_overwrite"};
    vecs[11] = '{1'b0, 32'hC, 32'h0,        32'h2,  "txfull_still"};
    vecs[12] = '{1'b1, 32'hC, 32'h000000FF, 32'h0,  "w1c_all"};
    vecs[13] = '{1'b0, 32'hC, 32'h0,        32'h2,  "w1c_keeps_txfull"};
    vecs[14] = '{1'b1, 32'h0, 32'h0,        32'h0,  "wr_ctrl_zero"};
    vecs[15] = '{1'b0, 32'h0, 32'h0,        32'h0,  "ctrl_cleared"};

    tick(3);
    HRESETn = 1'b1;
    tick(1);
    check("rst_miso_en", {31'd0, MISO_EN}, 32'h0);
    check("rst_miso", {31'd0, MISO}, 32'h0);
    check("rst_irq", {31'd0, IRQ}, 32'h0);
    check("rst_hrdata", HRDATA, 32'h0);
    check("hreadyout", {31'd0, HREADYOUT}, 32'h1);

    for (int i = 0; i < 16; i++) begin
      if (vecs[i].wr) ahb_write(vecs[i].addr, vecs[i].wdata);
      else read_check(vecs[i].name, vecs[i].addr, vecs[i].exp);
    end

    // Single frame: TX A5, RX 3C, IRQ and read-clear
    ahb_write(32'h0, 32'h3);
    ahb_write(32'h4, 32'hA5);
    CS_N = 1'b0;
    tick(8);
    check("f1_miso_en", {31'd0, MISO_EN}, 32'h1);
    read_check("f1_busy", 32'hC, 32'h4);
    spi_xfer(8'h3C, 8, rxb, ens);
    check("f1_miso_bits", {24'd0, rxb}, 32'hA5);
    CS_N = 1'b1;
    tick(8);
    check("f1_miso_en_off", {31'd0, MISO_EN}, 32'h0);
    check("f1_irq", {31'd0, IRQ}, 32'h1);
    read_check("f1_status", 32'hC, 32'h1);
    read_check("f1_rxdata", 32'h8, 32'h3C);
    read_check("f1_status_clr", 32'hC, 32'h0);
    check("f1_irq_clr", {31'd0, IRQ}, 32'h0);

    // Two bytes under one CS_N low with no TX data: underrun and overrun
    CS_N = 1'b0;
    tick(8);
    spi_xfer(8'h11, 8, rxb, ens);
    check("f2_miso0", {24'd0, rxb}, 32'hFF);
    spi_xfer(8'h22, 8, rxb, ens);
    check("f2_miso1", {24'd0, rxb}, 32'hFF);
    CS_N = 1'b1;
    tick(8);
    check("f2_irq", {31'd0, IRQ}, 32'h1);
    read_check("f2_status", 32'hC, 32'h19);
    ahb_write(32'hC, 32'h18);
    read_check("f2_status_w1c", 32'hC, 32'h1);
    read_check("f2_rxdata", 32'h8, 32'h22);

    // Partial byte discarded, then a full byte
    CS_N = 1'b0;
    tick(8);
    spi_xfer(8'hA0, 5, rxb, ens);
    read_check("f3_busy_partial", 32'hC, 32'h14);
    CS_N = 1'b1;
    tick(8);
    read_check("f3_after_abort", 32'hC, 32'h10);
    CS_N = 1'b0;
    tick(8);
    spi_xfer(8'h81, 8, rxb, ens);
    CS_N = 1'b1;
    tick(8);
    read_check("f3_rxdata", 32'h8, 32'h81);
    read_check("f3_status", 32'hC, 32'h10);
    ahb_write(32'hC, 32'h18);

    // Reset mid-frame with CS_N held low
    CS_N = 1'b0;
    tick(8);
    spi_xfer(8'hFF, 4, rxb, ens);
    HRESETn = 1'b0;
    tick(2);
    HRESETn = 1'b1;
    tick(1);
    check("f4_rst_miso_en", {31'd0, MISO_EN}, 32'h0);
    read_check("f4_rst_ctrl", 32'h0, 32'h0);
    ahb_write(32'h0, 32'h3);
    spi_xfer(8'h77, 8, rxb, ens);
    check("f4_no_start", {31'd0, ens}, 32'h0);
    read_check("f4_no_rx", 32'hC, 32'h0);
    CS_N = 1'b1;
    tick(8);
    CS_N = 1'b0;
    tick(8);
    spi_xfer(8'h5A, 8, rxb, ens);
    CS_N = 1'b1;
    tick(8);
    check("f4_irq", {31'd0, IRQ}, 32'h1);
    read_check("f4_rxdata", 32'h8, 32'h5A);
    read_check("f4_status", 32'hC, 32'h10);
    ahb_write(32'hC, 32'h18);

    // Disabled: frame ignored
    ahb_write(32'h0, 32'h0);
    CS_N = 1'b0;
    tick(8);
    spi_xfer(8'hC3, 8, rxb, ens);
    check("f5_miso_en", {31'd0, ens}, 32'h0);
    check("f5_miso_zero", {24'd0, rxb}, 32'h0);
    CS_N = 1'b1;
    tick(8);
    read_check("f5_rxdata", 32'h8, 32'h5A);
    read_check("f5_status", 32'hC, 32'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
